// File: rtl/trdb_packet_sched_if.sv
// Format/subformat types and the request/packet bundle of the trace packet scheduler.
// Latency: n/a (wiring only).
// Backpressure: pkt side is valid/ready; the request side has no ready (drops are counted instead).
package trdb_pkg;
    typedef enum logic [1:0] {
        F_BRANCH_FULL = 2'h0,
        F_BRANCH_DIFF = 2'h1,
        F_ADDR_ONLY   = 2'h2,
        F_SYNC        = 2'h3
    } trdb_format_t;

    typedef enum logic [1:0] {
        SF_START     = 2'h0,
        SF_EXCEPTION = 2'h1,
        SF_CONTEXT   = 2'h2,
        SF_UNDEF     = 2'h3
    } trdb_subformat_t;
endpackage

interface trdb_packet_sched_if import trdb_pkg::*; #(
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 4
);
    logic                     req_valid_i;
    trdb_format_t             req_format_i;
    trdb_subformat_t          req_subformat_i;
    logic [PAYLOAD_W-1:0]     req_payload_i;
    logic                     pkt_valid_o;
    logic                     pkt_ready_i;
    trdb_format_t             pkt_format_o;
    trdb_subformat_t          pkt_subformat_o;
    logic [PAYLOAD_W-1:0]     pkt_payload_o;
    logic                     branch_map_flush_o;
    logic                     resync_o;
    logic                     lost_o;
    logic [7:0]               overflow_cnt_o;
    logic [$clog2(DEPTH):0]   fill_o;

    // Priority stage / encoder side
    modport master (
        output req_valid_i, req_format_i, req_subformat_i, req_payload_i, pkt_ready_i,
        input  pkt_valid_o, pkt_format_o, pkt_subformat_o, pkt_payload_o,
               branch_map_flush_o, resync_o, lost_o, overflow_cnt_o, fill_o
    );

    // Scheduler side
    modport slave (
        input  req_valid_i, req_format_i, req_subformat_i, req_payload_i, pkt_ready_i,
        output pkt_valid_o, pkt_format_o, pkt_subformat_o, pkt_payload_o,
               branch_map_flush_o, resync_o, lost_o, overflow_cnt_o, fill_o
    );
endinterface

// File: rtl/trdb_packet_sched.sv
// Packet scheduler: queues trace packet requests in a DEPTH-entry FIFO, tracks loss and periodic resync.
// Latency: a commit in cycle N is visible on pkt_* in cycle N+1 when the FIFO is empty.
// Backpressure: pkt_ready_i low fills the FIFO; requests without space are dropped and counted.
module trdb_packet_sched import trdb_pkg::*; #(
    parameter int DEPTH      = 4,
    parameter int PAYLOAD_W  = 64,
    parameter int RESYNC_MAX = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    trdb_packet_sched_if.slave   ifc
);
    localparam int              AW    = $clog2(DEPTH);
    localparam logic [AW:0]     FULL  = (AW+1)'(DEPTH);
    localparam logic [15:0]     RMAX  = 16'(RESYNC_MAX);
    localparam logic [0:0]      RUN   = 1'b0;
    localparam logic [0:0]      LOST  = 1'b1;

    typedef struct packed {
        trdb_format_t          fmt;
        trdb_subformat_t       sf;
        logic [PAYLOAD_W-1:0]  payload;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     fill;
    logic [0:0]      state;
    logic [15:0]     rcnt;
    logic [7:0]      ovf;
    logic            pkt_vld, pop, space, admitted, is_sync, commit, drop;

    assign pkt_vld  = (fill != '0);
    assign pop      = pkt_vld & ifc.pkt_ready_i;
    assign space    = (fill != FULL) | pop;
    assign is_sync  = (ifc.req_format_i == F_SYNC);
    assign admitted = (state == RUN) | is_sync;
    // clear_i discards the concurrent request, so it neither commits nor counts as a drop
    assign commit   = ifc.req_valid_i & space & admitted & ~clear_i;
    assign drop     = ifc.req_valid_i & ~commit & ~clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            state  <= RUN;
            rcnt   <= '0;
            ovf    <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            state  <= RUN;
            rcnt   <= '0;
            ovf    <= '0;
        end else begin
            if (commit) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({commit, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase

            // Any drop means history was lost; only a committed sync restores it
            if (drop)                   state <= LOST;
            else if (commit && is_sync) state <= RUN;

            if (drop && ovf != 8'hFF) ovf <= ovf + 8'd1;

            if (commit) begin
                if (is_sync)           rcnt <= '0;
                else if (rcnt != RMAX) rcnt <= rcnt + 16'd1;
            end
        end
    end

    // Storage is written only on commit; its contents are qualified by fill, so no reset needed
    always_ff @(posedge clk_i) begin
        if (commit) mem[wr_ptr] <= '{fmt: ifc.req_format_i, sf: ifc.req_subformat_i,
                                     payload: ifc.req_payload_i};
    end

    assign head = mem[rd_ptr];

    assign ifc.pkt_valid_o        = pkt_vld;
    assign ifc.pkt_format_o       = pkt_vld ? head.fmt : F_BRANCH_FULL;
    assign ifc.pkt_subformat_o    = pkt_vld ? head.sf  : SF_START;
    assign ifc.pkt_payload_o      = pkt_vld ? head.payload : '0;
    assign ifc.branch_map_flush_o = commit;
    assign ifc.lost_o             = (state == LOST);
    assign ifc.resync_o           = (rcnt == RMAX) | (state == LOST);
    assign ifc.overflow_cnt_o     = ovf;
    assign ifc.fill_o             = fill;
endmodule

// File: tb/tb_trdb_packet_sched.sv
// Bench for trdb_packet_sched: vector table, hand sequences and random traffic against a queue model.
module tb_trdb_packet_sched;
    import trdb_pkg::*;

    localparam int DEPTH      = 4;
    localparam int PAYLOAD_W  = 64;
    localparam int RESYNC_MAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    trdb_packet_sched_if #(.PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH)) ifc ();

    trdb_packet_sched #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .RESYNC_MAX(RESYNC_MAX)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .ifc     (ifc)
    );

    int n_err = 0;
    int n_chk = 0;

    typedef struct packed {
        logic [1:0]  f;
        logic [1:0]  s;
        logic [63:0] p;
    } ent_t;

    ent_t mq[$];
    bit   m_lost;
    int   m_ovf;
    int   m_rcnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_lost = 0;
        m_ovf  = 0;
        m_rcnt = 0;
    endtask

    task automatic check_outputs();
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("pkt_valid", ifc.pkt_valid_o, mq.size() > 0);
        chk("pkt_format", ifc.pkt_format_o, h.f);
        chk("pkt_subformat", ifc.pkt_subformat_o, h.s);
        chk("pkt_payload", ifc.pkt_payload_o, h.p);
        chk("fill", ifc.fill_o, mq.size());
        chk("lost", ifc.lost_o, m_lost);
        chk("resync", ifc.resync_o, (m_rcnt == RESYNC_MAX) || m_lost);
        chk("overflow_cnt", ifc.overflow_cnt_o, m_ovf);
    endtask

    // Called shortly after a falling edge; returns the observed flush pulse
    task automatic step(input logic v, input trdb_format_t f, input trdb_subformat_t s,
                        input logic [63:0] p, input logic r, input logic c,
                        output logic got_flush);
        int  sz;
        bit  pop, space, adm, com;
        ifc.req_valid_i     = v;
        ifc.req_format_i    = f;
        ifc.req_subformat_i = s;
        ifc.req_payload_i   = p;
        ifc.pkt_ready_i     = r;
        clear               = c;
        #1;
        sz    = mq.size();
        pop   = (sz > 0) && r;
        space = (sz < DEPTH) || pop;
        adm   = !m_lost || (f == F_SYNC);
        com   = v && space && adm && !c;
        got_flush = ifc.branch_map_flush_o;
        chk("flush", got_flush, com);
        if (c) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (com) mq.push_back('{f: f, s: s, p: p});
            if (v && !com) begin
                m_lost = 1;
                if (m_ovf < 255) m_ovf++;
            end
            if (com && f == F_SYNC) begin
                m_lost = 0;
                m_rcnt = 0;
            end else if (com && m_rcnt < RESYNC_MAX) begin
                m_rcnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        ifc.req_valid_i     = 1'b0;
        ifc.req_format_i    = F_BRANCH_FULL;
        ifc.req_subformat_i = SF_START;
        ifc.req_payload_i   = '0;
        ifc.pkt_ready_i     = 1'b0;
        clear               = 1'b0;
    endtask

    typedef struct {
        logic          v;
        trdb_format_t  f;
        logic          r;
        logic          c;
        logic          e_flush;
        int            e_fill;
        logic          e_lost;
        logic          e_resync;
        int            e_ovf;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic fl;
        int   flushes;
        logic [63:0] pl;

        // Overflow, recovery, full push/pop and clear with hand-derived results
        tbl[0]  = '{1'b1, F_BRANCH_FULL, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, F_BRANCH_FULL, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, F_BRANCH_FULL, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b1, F_BRANCH_FULL, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b1, 0};
        tbl[4]  = '{1'b1, F_BRANCH_FULL, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1};
        tbl[5]  = '{1'b1, F_BRANCH_FULL, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 2};
        tbl[6]  = '{1'b1, F_BRANCH_FULL, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1, 3};
        tbl[7]  = '{1'b1, F_SYNC,        1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 3};
        tbl[8]  = '{1'b1, F_ADDR_ONLY,   1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 3};
        tbl[9]  = '{1'b1, F_ADDR_ONLY,   1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0, 3};
        tbl[10] = '{1'b0, F_ADDR_ONLY,   1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 3};
        tbl[11] = '{1'b1, F_ADDR_ONLY,   1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};

        idle_inputs();
        model_reset();
        #12;
        check_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].f, SF_START, 64'hA000 + 64'(i), tbl[i].r, tbl[i].c, fl);
            chk($sformatf("tbl%0d_flush", i), fl, tbl[i].e_flush);
            chk($sformatf("tbl%0d_fill", i), ifc.fill_o, tbl[i].e_fill);
            chk($sformatf("tbl%0d_lost", i), ifc.lost_o, tbl[i].e_lost);
            chk($sformatf("tbl%0d_resync", i), ifc.resync_o, tbl[i].e_resync);
            chk($sformatf("tbl%0d_ovf", i), ifc.overflow_cnt_o, tbl[i].e_ovf);
        end
        chk("clear_pkt_valid", ifc.pkt_valid_o, 1'b0);

        // Streaming at one-cycle latency
        flushes = 0;
        for (int i = 0; i < 10; i++) begin
            pl = 64'h5000_0000 + 64'(i);
            step(1'b1, F_ADDR_ONLY, SF_START, pl, 1'b1, 1'b0, fl);
            if (fl) flushes++;
            chk("stream_head", ifc.pkt_payload_o, pl);
            chk("stream_fill_le1", ifc.fill_o <= 1, 1'b1);
        end
        chk("stream_flushes", flushes, 10);

        // Periodic resync with RESYNC_MAX=3
        step(1'b0, F_ADDR_ONLY, SF_START, 64'h0, 1'b1, 1'b1, fl);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, F_ADDR_ONLY, SF_START, 64'h600 + 64'(i), 1'b1, 1'b0, fl);
            chk("periodic_resync", ifc.resync_o, i == 2);
        end
        step(1'b1, F_SYNC, SF_START, 64'h6FF, 1'b1, 1'b0, fl);
        chk("periodic_resync_sync", ifc.resync_o, 1'b0);

        // Overflow counter saturation
        step(1'b0, F_ADDR_ONLY, SF_START, 64'h0, 1'b0, 1'b1, fl);
        for (int i = 0; i < DEPTH + 260; i++)
            step(1'b1, F_BRANCH_DIFF, SF_START, 64'(i), 1'b0, 1'b0, fl);
        chk("ovf_saturate", ifc.overflow_cnt_o, 8'd255);

        // Asynchronous reset mid-stream
        step(1'b0, F_ADDR_ONLY, SF_START, 64'h0, 1'b0, 1'b1, fl);
        for (int i = 0; i < 3; i++)
            step(1'b1, F_BRANCH_DIFF, SF_CONTEXT, 64'h700 + 64'(i), 1'b0, 1'b0, fl);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_flush", ifc.branch_map_flush_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();
        @(negedge clk);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 7),
                 trdb_format_t'(2'($urandom_range(0, 3))),
                 trdb_subformat_t'(2'($urandom_range(0, 3))),
                 {$urandom, $urandom},
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 63) == 0),
                 fl);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
